// File: rtl/word_enumerator_pkg.sv
// Package word_enum_pkg: shared definitions for the word enumerator.
// Contents:
//   state_t     - FSM state encoding (IDLE, ARST, SHIFT, CHECK, DONE)
//   CEX_COUNT_W - width of the optional counterexample counter
//   len_width() - number of bits needed to hold a length 0..max_len
package word_enum_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARST  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int CEX_COUNT_W = 16;

  // Bits needed to represent every length from 0 to max_len inclusive.
  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/word_enumerator_if.sv
// Interface word_enumerator_if: bundles the run-control, result and
// automata-drive signals of the word enumerator.
// Optional macro: CEX_COUNT_EN adds the 16-bit cex_count result.
// Signals:
//   start                 - begin a run
//   busy, done            - run status
//   mismatch              - some word was judged differently
//   cex_word, cex_len     - first distinguishing word and its length
//   sym_out, auto_reset   - drive to both automata
//   out1, out2            - accept outputs of the two automata
//   cex_count             - (CEX_COUNT_EN) number of distinguishing words
// Modports: master = enumerator side, slave = environment side.
interface word_enumerator_if
  import word_enum_pkg::*;
#(
  parameter int MAX_LEN = 8
);
  localparam int LEN_W = len_width(MAX_LEN);

  logic               start;
  logic               busy;
  logic               done;
  logic               mismatch;
  logic [MAX_LEN-1:0] cex_word;
  logic [LEN_W-1:0]   cex_len;
  logic               sym_out;
  logic               auto_reset;
  logic               out1;
  logic               out2;
`ifdef CEX_COUNT_EN
  logic [CEX_COUNT_W-1:0] cex_count;

  modport master (
    input  start, out1, out2,
    output busy, done, mismatch, cex_word, cex_len, sym_out, auto_reset,
           cex_count
  );
  modport slave (
    output start, out1, out2,
    input  busy, done, mismatch, cex_word, cex_len, sym_out, auto_reset,
           cex_count
  );
`else
  modport master (
    input  start, out1, out2,
    output busy, done, mismatch, cex_word, cex_len, sym_out, auto_reset
  );
  modport slave (
    output start, out1, out2,
    input  busy, done, mismatch, cex_word, cex_len, sym_out, auto_reset
  );
`endif

endinterface

// File: rtl/word_enumerator_counter.sv
// Module word_counter: holds the current word length L, word value W and
// the symbol index within the word, and steps them through the order
// L=0..MAX_LEN, W=0..2^L-1.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   clear       - restart enumeration at L=0, W=0
//   step        - advance the symbol index (one SHIFT cycle consumed)
//   advance     - move to the next word (index back to 0)
//   len, word   - current L and W
//   last_sym    - index is on the final symbol of the word
//   last_word   - W is the last value for this length
//   last_len    - L has reached MAX_LEN
//   next_sym    - symbol that will be on the line in the coming cycle
module word_counter
  import word_enum_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = len_width(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               step,
  input  logic               advance,
  output logic [LEN_W-1:0]   len,
  output logic [MAX_LEN-1:0] word,
  output logic               last_sym,
  output logic               last_word,
  output logic               last_len,
  output logic               next_sym
);

  logic [LEN_W-1:0]   len_r;
  logic [MAX_LEN-1:0] word_r;
  logic [LEN_W-1:0]   idx_r;
  logic [LEN_W-1:0]   idx_nxt_s;
  logic [MAX_LEN-1:0] len_mask_s;

  // Next-index select, symbol lookup and the mask of bits below L.
  always_comb begin
    idx_nxt_s  = step ? (idx_r + LEN_W'(1'b1)) : idx_r;
    next_sym   = 1'b0;
    len_mask_s = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      next_sym      = (idx_nxt_s == LEN_W'(i)) ? word_r[i] : next_sym;
      len_mask_s[i] = (LEN_W'(i) < len_r);
    end
  end

  // W is the last value for length L when every bit below L is set
  // (trivially true for L=0, where the only word is empty).
  assign last_word = &(word_r | ~len_mask_s);
  assign last_len  = (len_r == LEN_W'(MAX_LEN));
  assign last_sym  = ((idx_r + LEN_W'(1'b1)) == len_r);
  assign len       = len_r;
  assign word      = word_r;

  // Length / word / index registers with wrap from the last W into L+1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_r  <= '0;
      word_r <= '0;
      idx_r  <= '0;
    end else if (clear) begin
      len_r  <= '0;
      word_r <= '0;
      idx_r  <= '0;
    end else if (advance) begin
      idx_r <= '0;
      if (last_word) begin
        len_r  <= len_r + LEN_W'(1'b1);
        word_r <= '0;
      end else begin
        word_r <= word_r + MAX_LEN'(1'b1);
      end
    end else if (step) begin
      idx_r <= idx_nxt_s;
    end
  end

endmodule

// File: rtl/word_enumerator.sv
// Module word_enumerator: feeds every word over {0,1} of length 0..MAX_LEN
// (shortest first, then by value, LSB-first) to two automata in lockstep
// and reports the first word on which their accept outputs differ.
// Each word: one ARST cycle (automata reset), L SHIFT cycles (symbols),
// one CHECK cycle (compare out1/out2).
// Optional macro: CEX_COUNT_EN - run continues after a mismatch and the
// number of distinguishing words is reported on cex_count (saturating).
// Ports:
//   clk    - clock
//   reset  - asynchronous active-high reset
//   bus    - word_enumerator_if.master (start, status, result, automata
//            drive sym_out/auto_reset, automata outputs out1/out2)
module word_enumerator
  import word_enum_pkg::*;
#(
  parameter int MAX_LEN = 8
) (
  input  logic              clk,
  input  logic              reset,
  word_enumerator_if.master bus
);

  localparam int LEN_W = len_width(MAX_LEN);

  state_t             state_r;
  state_t             state_next_s;
  logic               cnt_clear_s;
  logic               cnt_step_s;
  logic               cnt_advance_s;
  logic               capture_s;
  logic               mism_s;
  logic [LEN_W-1:0]   len_s;
  logic [MAX_LEN-1:0] word_s;
  logic               last_sym_s;
  logic               last_word_s;
  logic               last_len_s;
  logic               next_sym_s;

  logic               auto_reset_r;
  logic               sym_out_r;
  logic               busy_r;
  logic               done_r;
  logic               mismatch_r;
  logic [MAX_LEN-1:0] cex_word_r;
  logic [LEN_W-1:0]   cex_len_r;
`ifdef CEX_COUNT_EN
  logic                   count_s;
  logic [CEX_COUNT_W-1:0] cex_count_r;
`endif

  word_counter #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_counter (
    .clk       (clk),
    .reset     (reset),
    .clear     (cnt_clear_s),
    .step      (cnt_step_s),
    .advance   (cnt_advance_s),
    .len       (len_s),
    .word      (word_s),
    .last_sym  (last_sym_s),
    .last_word (last_word_s),
    .last_len  (last_len_s),
    .next_sym  (next_sym_s)
  );

  assign mism_s = bus.out1 ^ bus.out2;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and counter control.
  always_comb begin
    state_next_s  = state_r;
    cnt_clear_s   = 1'b0;
    cnt_step_s    = 1'b0;
    cnt_advance_s = 1'b0;
    capture_s     = 1'b0;
`ifdef CEX_COUNT_EN
    count_s       = 1'b0;
`endif
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          cnt_clear_s  = 1'b1;
          state_next_s = ST_ARST;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_ARST: begin
        state_next_s = (len_s != '0) ? ST_SHIFT : ST_CHECK;
      end
      ST_SHIFT: begin
        cnt_step_s   = 1'b1;
        state_next_s = last_sym_s ? ST_CHECK : ST_SHIFT;
      end
      ST_CHECK: begin
`ifdef CEX_COUNT_EN
        // Keep going after a mismatch; only the first one is captured.
        count_s   = mism_s;
        capture_s = mism_s & ~mismatch_r;
        if (last_word_s && last_len_s) begin
          state_next_s = ST_DONE;
        end else begin
          cnt_advance_s = 1'b1;
          state_next_s  = ST_ARST;
        end
`else
        if (mism_s) begin
          capture_s    = 1'b1;
          state_next_s = ST_DONE;
        end else if (last_word_s && last_len_s) begin
          state_next_s = ST_DONE;
        end else begin
          cnt_advance_s = 1'b1;
          state_next_s  = ST_ARST;
        end
`endif
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state they describe; results are cleared on start and set on capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      auto_reset_r <= 1'b1;
      sym_out_r    <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      mismatch_r   <= 1'b0;
      cex_word_r   <= '0;
      cex_len_r    <= '0;
    end else begin
      auto_reset_r <= (state_next_s == ST_IDLE) || (state_next_s == ST_ARST) ||
                      (state_next_s == ST_DONE);
      sym_out_r    <= (state_next_s == ST_SHIFT) ? next_sym_s : 1'b0;
      busy_r       <= (state_next_s == ST_ARST) || (state_next_s == ST_SHIFT) ||
                      (state_next_s == ST_CHECK);
      done_r       <= (state_next_s == ST_DONE);
      if (cnt_clear_s) begin
        mismatch_r <= 1'b0;
        cex_word_r <= '0;
        cex_len_r  <= '0;
      end else if (capture_s) begin
        mismatch_r <= 1'b1;
        cex_word_r <= word_s;
        cex_len_r  <= len_s;
      end
    end
  end

`ifdef CEX_COUNT_EN
  // Saturating count of distinguishing words.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cex_count_r <= '0;
    end else if (cnt_clear_s) begin
      cex_count_r <= '0;
    end else if (count_s && (cex_count_r != {CEX_COUNT_W{1'b1}})) begin
      cex_count_r <= cex_count_r + CEX_COUNT_W'(1'b1);
    end
  end

  assign bus.cex_count = cex_count_r;
`endif

  assign bus.auto_reset = auto_reset_r;
  assign bus.sym_out    = sym_out_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.mismatch   = mismatch_r;
  assign bus.cex_word   = cex_word_r;
  assign bus.cex_len    = cex_len_r;

endmodule

// File: tb/tb_word_enumerator.sv
// Testbench for word_enumerator: two table-driven Moore automata are fed
// from sym_out/auto_reset; a word-level reference model runs the same
// tables over every word in enumeration order to predict the result.
module tb_word_enumerator;
  import word_enum_pkg::*;

  localparam int MAX_LEN = 3;
  localparam int BUDGET  = 2000;

  logic clk;
  logic reset;

  word_enumerator_if #(.MAX_LEN(MAX_LEN)) bus ();

  word_enumerator #(.MAX_LEN(MAX_LEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Automata: 4 states, transition tables t[state][symbol], accept maps.
  logic [1:0] t1 [4][2];
  logic [1:0] t2 [4][2];
  logic       acc1 [4];
  logic       acc2 [4];
  logic [1:0] q1;
  logic [1:0] q2;

  int checks = 0;
  int errors = 0;
  int exp_mm, exp_len, exp_word, exp_cyc, exp_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    q1 <= bus.auto_reset ? 2'd0 : t1[q1][bus.sym_out];
    q2 <= bus.auto_reset ? 2'd0 : t2[q2][bus.sym_out];
  end
  assign bus.out1 = acc1[q1];
  assign bus.out2 = acc2[q2];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // kind 0: always reject, 1: accepts words ending in 1, 2: random.
  task automatic cfg(input int which, input int kind);
    for (int q = 0; q < 4; q++) begin
      for (int s = 0; s < 2; s++) begin
        logic [1:0] nx;
        nx = (kind == 1) ? 2'(s) : (kind == 2) ? 2'($urandom_range(3)) : 2'd0;
        if (which == 1) t1[q][s] = nx; else t2[q][s] = nx;
      end
      if (which == 1) acc1[q] = (kind == 1) ? (q == 1) : (kind == 2) ? 1'($urandom_range(1)) : 1'b0;
      else            acc2[q] = (kind == 1) ? (q == 1) : (kind == 2) ? 1'($urandom_range(1)) : 1'b0;
    end
  endtask

  function automatic bit dfa_accepts(input int which, input int len, input int w);
    int q = 0;
    for (int i = 0; i < len; i++) q = (which == 1) ? int'(t1[q][(w >> i) & 1]) : int'(t2[q][(w >> i) & 1]);
    return (which == 1) ? acc1[q] : acc2[q];
  endfunction

  // Enumerate every word of length 0..MAX_LEN in value order.
  task automatic model_run();
    bit stopped = 1'b0;
    exp_mm = 0; exp_len = 0; exp_word = 0; exp_cyc = 0; exp_cnt = 0;
    for (int l = 0; l <= MAX_LEN; l++) begin
      for (int w = 0; w < (1 << l); w++) begin
        if (!stopped) begin
          exp_cyc += l + 2;
          if (dfa_accepts(1, l, w) != dfa_accepts(2, l, w)) begin
            exp_cnt++;
            if (exp_mm == 0) begin
              exp_mm = 1; exp_len = l; exp_word = w;
            end
`ifndef CEX_COUNT_EN
            stopped = 1'b1;
`endif
          end
        end
      end
    end
  endtask

  // Cycles from the start edge to the ARST of word (len, w).
  function automatic int word_offset(input int len, input int w);
    int o = 0;
    for (int l = 0; l < len; l++) o += (l + 2) * (1 << l);
    return o + w * (len + 2);
  endfunction

  task automatic pulse_start();
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < BUDGET) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic check_result(input string tag, input int n);
    check({tag, "_cycles"}, n, exp_cyc);
    check({tag, "_done"}, int'(bus.done), 1);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_arst"}, int'(bus.auto_reset), 1);
    check({tag, "_mismatch"}, int'(bus.mismatch), exp_mm);
    check({tag, "_cex_len"}, int'(bus.cex_len), exp_len);
    check({tag, "_cex_word"}, int'(bus.cex_word), exp_word);
`ifdef CEX_COUNT_EN
    check({tag, "_cex_count"}, int'(bus.cex_count), exp_cnt);
`endif
  endtask

  task automatic run_and_check(input string tag);
    int n;
    model_run();
    pulse_start();
    wait_done(n);
    check_result(tag, n);
  endtask

  initial begin
    int n;
    int off;
    reset = 1'b1;
    bus.start = 1'b0;
    cfg(1, 1); cfg(2, 1);
    #3;
    check("rst_auto_reset", int'(bus.auto_reset), 1);
    check("rst_sym_out", int'(bus.sym_out), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_mismatch", int'(bus.mismatch), 0);
    check("rst_cex_word", int'(bus.cex_word), 0);
    check("rst_cex_len", int'(bus.cex_len), 0);
`ifdef CEX_COUNT_EN
    check("rst_cex_count", int'(bus.cex_count), 0);
`endif
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("idle_auto_reset", int'(bus.auto_reset), 1);

    // Identical ends-in-1 automata: full run, no mismatch.
    run_and_check("equal");

    // out2 always 0 against ends-in-1: first distinguishing word is "1".
    cfg(2, 0);
    run_and_check("ends1_vs_0");

    // Symbol trace for L=3, W=6 with equal automata.
    cfg(2, 1);
    model_run();
    pulse_start();
    off = word_offset(3, 6);
    repeat (off) @(posedge clk);
    #1;
    check("trace_arst", int'(bus.auto_reset), 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("trace_sym%0d", i), int'(bus.sym_out), (6 >> i) & 1);
      check($sformatf("trace_ar%0d", i), int'(bus.auto_reset), 0);
    end
    @(posedge clk); #1;
    check("trace_check_sym", int'(bus.sym_out), 0);
    check("trace_check_ar", int'(bus.auto_reset), 0);
    check("trace_check_busy", int'(bus.busy), 1);
    wait_done(n);
    check("trace_run_cycles", n + off + 4, exp_cyc);

    // Asynchronous reset on the 2nd SHIFT cycle of L=2, W=3.
    pulse_start();
    repeat (word_offset(2, 3) + 2) @(posedge clk);
    #1;
    check("midshift_sym", int'(bus.sym_out), 1);
    check("midshift_ar", int'(bus.auto_reset), 0);
    reset = 1'b1;
    #1;
    check("async_rst_ar", int'(bus.auto_reset), 1);
    check("async_rst_busy", int'(bus.busy), 0);
    check("async_rst_sym", int'(bus.sym_out), 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("after_rst_busy", int'(bus.busy), 0);
    check("after_rst_ar", int'(bus.auto_reset), 1);
    // Replay must begin at L=0: ARST, CHECK, then ARST again.
    pulse_start();
    check("replay_c0_ar", int'(bus.auto_reset), 1);
    @(posedge clk); #1;
    check("replay_c1_ar", int'(bus.auto_reset), 0);
    check("replay_c1_busy", int'(bus.busy), 1);
    @(posedge clk); #1;
    check("replay_c2_ar", int'(bus.auto_reset), 1);
    wait_done(n);
    check("replay_cycles", n + 2, exp_cyc);
    check("replay_mismatch", int'(bus.mismatch), exp_mm);

    // start held high: no restart while busy, restart right after DONE.
    cfg(2, 0);
    model_run();
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk); #1;
    wait_done(n);
    check_result("hold", n);
    @(posedge clk); #1;
    check("hold_restart_done", int'(bus.done), 0);
    check("hold_restart_busy", int'(bus.busy), 1);
    check("hold_restart_mm", int'(bus.mismatch), 0);
    check("hold_restart_len", int'(bus.cex_len), 0);
    bus.start = 1'b0;
    wait_done(n);
    check_result("hold2", n);

    // Randomized automata pairs, including identical copies.
    for (int r = 0; r < 16; r++) begin
      @(negedge clk);
      cfg(1, 2);
      if (r % 4 == 3) begin
        t2 = t1; acc2 = acc1;
      end else begin
        cfg(2, 2);
      end
      run_and_check($sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
